// File: rtl/mac_window_engine_pkg.sv
// Shared types and constants for the windowed multiply-accumulate engine.
// Optional feature macro: MAC_SAT_EN (saturating accumulate, sticky STATUS bit1).
package mac_window_engine_pkg;

  localparam int unsigned CMD_AW = 5;
  localparam int unsigned CMD_DW = 32;
  localparam int unsigned TAPS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [CMD_AW-1:0] REG_VEC_ADDR    = 5'h00;
  localparam logic [CMD_AW-1:0] REG_START       = 5'h04;
  localparam logic [CMD_AW-1:0] REG_ACC         = 5'h08;
  localparam logic [CMD_AW-1:0] REG_STATUS      = 5'h0C;
  localparam logic [CMD_AW-1:0] REG_ADDR_STRIDE = 5'h10;
  localparam logic [CMD_AW-1:0] REG_COEF_STRIDE = 5'h14;
  localparam logic [CMD_AW-1:0] REG_TAPS        = 5'h18;
  localparam logic [CMD_AW-1:0] REG_CH_SEL      = 5'h1C;

  localparam int unsigned DEF_ADDR_STRIDE = 128;
  localparam int unsigned DEF_COEF_STRIDE = 64;
  localparam int unsigned DEF_TAPS        = 8;

  // Fold an out-of-range channel number back into 0..n-1.
  function automatic logic [2:0] ch_wrap(input logic [2:0] ch, input int unsigned n);
    return 3'(32'(ch) % n);
  endfunction

endpackage

// File: rtl/mac_window_engine_if.sv
// CPU register command/response bus of the MAC window engine.
interface mac_window_engine_if;
  import mac_window_engine_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [CMD_AW-1:0] cmd_addr;
  logic [CMD_DW-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [CMD_DW-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mac_window_engine_mac_pipe.sv
// Operand, product and accumulate-add stages of the MAC engine.
// MAC_SAT_EN selects a saturating add; otherwise the add wraps.
module mac_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned COEF_W = 18,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tap_vld,
  input  logic                     tap_last,
  input  logic signed [DATA_W-1:0] mem_data,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [ACC_W-1:0]  acc_cur,
  output logic                     acc_we_c,
  output logic                     acc_last_c,
  output logic signed [ACC_W-1:0]  acc_sum_c,
  output logic                     acc_sat_c
);

  localparam int unsigned PW = DATA_W + COEF_W;

  logic                     s1_vld, s1_last, s2_vld, s2_last, s3_vld, s3_last;
  logic signed [DATA_W-1:0] op_data_q;
  logic signed [COEF_W-1:0] op_coef_q;
  logic signed [ACC_W-1:0]  prod_q;

  // Valid/last tags follow the taps; operands are captured when memory data lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      s1_last   <= 1'b0;
      s2_vld    <= 1'b0;
      s2_last   <= 1'b0;
      s3_vld    <= 1'b0;
      s3_last   <= 1'b0;
      op_data_q <= '0;
      op_coef_q <= '0;
      prod_q    <= '0;
    end else begin
      s1_vld  <= tap_vld;
      s1_last <= tap_vld & tap_last;
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      s3_vld  <= s2_vld;
      s3_last <= s2_last;
      if (s1_vld) begin
        op_data_q <= mem_data;
        op_coef_q <= coef;
      end
      // Full-precision product, then resized to the accumulator width.
      if (s2_vld) prod_q <= ACC_W'(PW'(op_data_q) * PW'(op_coef_q));
    end
  end

  assign acc_we_c   = s3_vld;
  assign acc_last_c = s3_last;

`ifdef MAC_SAT_EN
  localparam int unsigned SW = ACC_W + 1;
  logic signed [ACC_W:0] sum_wide;
  logic                  ovf;

  // Saturating add: clamp to the extreme matching the true sign.
  always_comb begin
    sum_wide  = SW'(acc_cur) + SW'(prod_q);
    ovf       = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    acc_sum_c = sum_wide[ACC_W-1:0];
    if (ovf) acc_sum_c = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    acc_sat_c = s3_vld & ovf;
  end
`else
  // Two's-complement wrapping add.
  always_comb begin
    acc_sum_c = acc_cur + prod_q;
    acc_sat_c = 1'b0;
  end
`endif

endmodule

// File: rtl/mac_window_engine.sv
// Windowed multiply-accumulate engine: strided sample reads times coefficient
// ROM entries, accumulated into one of NUM_CH channel accumulators.
// Optional feature macro: MAC_SAT_EN (saturating accumulate, sticky STATUS bit1).
module mac_window_engine
  import mac_window_engine_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COEF_W  = 18,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned MEM_AW  = 19,
  parameter int unsigned COEF_IW = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  mac_window_engine_if.slave       cmd,
  output logic                     mem_rd_en,
  output logic [MEM_AW-1:0]        mem_rd_addr,
  input  logic signed [DATA_W-1:0] mem_rd_data,
  output logic [COEF_IW-1:0]       coef_idx,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     done
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e               state_q, state_n;
  logic [CMD_DW-1:0]    vec_addr_q;
  logic [MEM_AW-1:0]    astride_q;
  logic [COEF_IW-1:0]   cstride_q;
  logic [TAPS_W-1:0]    taps_q, cnt_q;
  logic [CH_W-1:0]      ch_sel_q, run_ch_q;
  logic                 sat_q;
  logic signed [ACC_W-1:0] acc_q [NUM_CH];

  logic accept_c, wr_c, rd_c, start_go_c, busy_c, issue_c, last_c;
  logic acc_we_c, acc_last_c, acc_sat_c;
  logic signed [ACC_W-1:0] acc_sum_c;
  logic [CMD_DW-1:0] rdata_c;

  // While busy only STATUS reads are accepted.
  assign busy_c        = (state_q != ST_IDLE);
  assign cmd.cmd_ready = !busy_c || (!cmd.cmd_write && cmd.cmd_addr == REG_STATUS);
  assign accept_c      = cmd.cmd_valid && cmd.cmd_ready;
  assign wr_c          = accept_c && cmd.cmd_write;
  assign rd_c          = accept_c && !cmd.cmd_write;
  assign start_go_c    = wr_c && cmd.cmd_addr == REG_START;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  // Next state and tap-issue strobes; a zero-tap run goes straight to DRAIN.
  always_comb begin
    state_n = state_q;
    issue_c = 1'b0;
    last_c  = 1'b0;
    case (state_q)
      ST_IDLE:  if (start_go_c) state_n = (taps_q == '0) ? ST_DRAIN : ST_RUN;
      ST_RUN: begin
        issue_c = 1'b1;
        if (cnt_q == TAPS_W'(1)) begin
          last_c  = 1'b1;
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: if (done) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Register read mux.
  always_comb begin
    rdata_c = '0;
    case (cmd.cmd_addr)
      REG_VEC_ADDR:    rdata_c = vec_addr_q;
      REG_ACC:         rdata_c = CMD_DW'(acc_q[ch_sel_q]);
      REG_STATUS:      rdata_c = {30'd0, sat_q, busy_c};
      REG_ADDR_STRIDE: rdata_c = CMD_DW'(astride_q);
      REG_COEF_STRIDE: rdata_c = CMD_DW'(cstride_q);
      REG_TAPS:        rdata_c = CMD_DW'(taps_q);
      REG_CH_SEL:      rdata_c = CMD_DW'(ch_sel_q);
      default:         rdata_c = '0;
    endcase
  end

  // Configuration registers, tap address generation, response and done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_addr_q    <= '0;
      astride_q     <= MEM_AW'(DEF_ADDR_STRIDE);
      cstride_q     <= COEF_IW'(DEF_COEF_STRIDE);
      taps_q        <= TAPS_W'(DEF_TAPS);
      ch_sel_q      <= '0;
      run_ch_q      <= '0;
      cnt_q         <= '0;
      sat_q         <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_rd_addr   <= '0;
      coef_idx      <= '0;
      done          <= 1'b0;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_rdata <= '0;
    end else begin
      if (wr_c) begin
        case (cmd.cmd_addr)
          REG_VEC_ADDR:    vec_addr_q <= cmd.cmd_wdata;
          REG_ADDR_STRIDE: astride_q  <= cmd.cmd_wdata[MEM_AW-1:0];
          REG_COEF_STRIDE: cstride_q  <= cmd.cmd_wdata[COEF_IW-1:0];
          REG_TAPS:        taps_q     <= cmd.cmd_wdata[TAPS_W-1:0];
          REG_CH_SEL:      ch_sel_q   <= CH_W'(ch_wrap(cmd.cmd_wdata[2:0], NUM_CH));
          default:         ;
        endcase
      end
      if (start_go_c) begin
        mem_rd_addr <= vec_addr_q[MEM_AW+1:2];
        coef_idx    <= cmd.cmd_wdata[COEF_IW-1:0];
        cnt_q       <= taps_q;
        run_ch_q    <= CH_W'(ch_wrap(cmd.cmd_wdata[18:16], NUM_CH));
        sat_q       <= 1'b0;
      end else if (issue_c) begin
        mem_rd_addr <= mem_rd_addr + astride_q;
        coef_idx    <= coef_idx + cstride_q;
        cnt_q       <= cnt_q - TAPS_W'(1);
      end
      if (acc_sat_c) sat_q <= 1'b1;
      mem_rd_en     <= (state_n == ST_RUN);
      done          <= (start_go_c && taps_q == '0) || (acc_we_c && acc_last_c);
      cmd.rsp_valid <= accept_c;
      cmd.rsp_rdata <= rd_c ? rdata_c : '0;
    end
  end

  // Channel accumulators: pipeline commits during a run, CPU writes when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) acc_q[i] <= '0;
    end else if (acc_we_c) begin
      acc_q[run_ch_q] <= acc_sum_c;
    end else if (wr_c && cmd.cmd_addr == REG_ACC) begin
      acc_q[ch_sel_q] <= ACC_W'(signed'(cmd.cmd_wdata));
    end
  end

  mac_pipe #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac_pipe (
    .clk        (clk),
    .reset      (reset),
    .tap_vld    (issue_c),
    .tap_last   (last_c),
    .mem_data   (mem_rd_data),
    .coef       (coef_data),
    .acc_cur    (acc_q[run_ch_q]),
    .acc_we_c   (acc_we_c),
    .acc_last_c (acc_last_c),
    .acc_sum_c  (acc_sum_c),
    .acc_sat_c  (acc_sat_c)
  );

endmodule

// File: tb/tb_mac_window_engine.sv
// Scoreboard bench for mac_window_engine: expected responses are queued at
// command acceptance and compared by an independent response monitor.
`timescale 1ns/1ps
module tb_mac_window_engine;
  import mac_window_engine_pkg::*;

  localparam int unsigned MEM_AW  = 19;
  localparam int unsigned COEF_IW = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_window_engine_if bus();
  logic                     mem_rd_en;
  logic [MEM_AW-1:0]        mem_rd_addr;
  logic signed [31:0]       mem_rd_data;
  logic [COEF_IW-1:0]       coef_idx;
  logic signed [17:0]       coef_data;
  logic                     done;

  mac_window_engine dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (bus),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .coef_idx    (coef_idx),
    .coef_data   (coef_data),
    .done        (done)
  );

  // Sample memory and coefficient ROM, both one cycle of latency.
  logic signed [31:0] mem [1024];
  logic signed [17:0] coef_val;
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[9:0]];
    coef_data <= coef_val;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_count = 0;
  int done_count = 0;
  int done_cyc = 0;
  logic [MEM_AW-1:0]  addr_log[$];
  logic [COEF_IW-1:0] idx_log[$];
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] sb_e;
  string       sb_n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: every rsp_valid pops one expected value.
  always @(negedge clk) begin
    if (!reset && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=0x%08h required=none", bus.rsp_rdata);
      end else begin
        sb_e = exp_q.pop_front();
        sb_n = name_q.pop_front();
        chk(sb_n, bus.rsp_rdata, sb_e);
      end
    end
  end

  // Activity monitor for tap issues and done pulses.
  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_count++;
      addr_log.push_back(mem_rd_addr);
      idx_log.push_back(coef_idx);
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic cpu(input logic wr, input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input string name, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    #1;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept actual=stalled required=accepted", name);
    end else begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    int c;
    cpu(1'b1, a, d, 32'd0, "wr_rsp", c);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    int c;
    cpu(1'b0, a, 32'd0, exp, name, c);
  endtask

  // START a run, confirm busy, wait for done and check tap count and timing.
  task automatic run(input logic [31:0] start_w, input int taps, input string name);
    int s, rd0, dn0, n;
    rd0 = rd_count;
    dn0 = done_count;
    addr_log.delete();
    idx_log.delete();
    cpu(1'b1, REG_START, start_w, 32'd0, {name, "_start_rsp"}, s);
    rd(REG_STATUS, 32'd1, {name, "_busy"});
    n = 0;
    while (done_count == dn0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, 32'(done_count - dn0), 32'd1);
    chk({name, "_rd_count"}, 32'(rd_count - rd0), 32'(taps));
    chk({name, "_done_cycle"}, 32'(done_cyc - s), (taps == 0) ? 32'd1 : 32'(taps + 4));
  endtask

  logic [31:0] sat_acc_exp, sat_status_exp;
  int dn_before, s_unused;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
`ifdef MAC_SAT_EN
    sat_acc_exp    = 32'h7FFF_FFFF;
    sat_status_exp = 32'd2;
`else
    sat_acc_exp    = 32'h8000_0054;
    sat_status_exp = 32'd0;
`endif
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int k = 0; k < 8; k++) mem[k * 128] = 32'(k + 1);
    coef_val      = 18'sd2;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b0;

    rd(REG_VEC_ADDR, 32'd0, "rst_vec_addr");
    rd(REG_ACC, 32'd0, "rst_acc");
    rd(REG_STATUS, 32'd0, "rst_status");
    rd(REG_ADDR_STRIDE, 32'd128, "rst_addr_stride");
    rd(REG_COEF_STRIDE, 32'd64, "rst_coef_stride");
    rd(REG_TAPS, 32'd8, "rst_taps");
    rd(REG_CH_SEL, 32'd0, "rst_ch_sel");

    // Default run: 2 * (1+..+8) = 72.
    run(32'd0, 8, "dflt");
    rd(REG_ACC, 32'd72, "dflt_acc");
    for (int k = 0; k < 8; k++) chk($sformatf("dflt_addr%0d", k), 32'(addr_log[k]), 32'(k * 128));

    // Undefined offset and read-only STATUS writes are ignored.
    wr(5'h01, 32'hDEAD_BEEF);
    rd(5'h01, 32'd0, "undef_rd");
    wr(REG_STATUS, 32'hFFFF_FFFF);
    rd(REG_STATUS, 32'd0, "status_ro");

    // Channel 1 run leaves channel 0 alone; CH_SEL wraps modulo NUM_CH.
    wr(REG_ACC, 32'd100);
    run(32'h0001_0000, 8, "ch1");
    rd(REG_ACC, 32'd100, "ch0_kept");
    wr(REG_CH_SEL, 32'd1);
    rd(REG_ACC, 32'd72, "ch1_acc");
    wr(REG_CH_SEL, 32'd3);
    rd(REG_CH_SEL, 32'd1, "ch_sel_wrap3");
    wr(REG_CH_SEL, 32'd2);
    rd(REG_CH_SEL, 32'd0, "ch_sel_wrap2");
    rd(REG_ACC, 32'd100, "ch0_again");

    // Zero taps: no reads, busy for one cycle, done next cycle.
    wr(REG_TAPS, 32'd0);
    run(32'd0, 0, "taps0");
    rd(REG_STATUS, 32'd0, "taps0_idle");
    rd(REG_ACC, 32'd100, "taps0_acc");

    // Index wrap 500,52,116; START channel 3 folds to channel 1 (72+12).
    wr(REG_TAPS, 32'd3);
    run(32'h0003_01F4, 3, "wrap");
    chk("wrap_idx0", 32'(idx_log[0]), 32'd500);
    chk("wrap_idx1", 32'(idx_log[1]), 32'd52);
    chk("wrap_idx2", 32'(idx_log[2]), 32'd116);
    rd(REG_ACC, 32'd100, "wrap_ch0");
    wr(REG_CH_SEL, 32'd1);
    rd(REG_ACC, 32'd84, "wrap_ch1");
    wr(REG_CH_SEL, 32'd0);

    // Overflow: 0x7FFFFFF0 + 100.
    wr(REG_TAPS, 32'd1);
    wr(REG_ACC, 32'h7FFF_FFF0);
    mem[0]   = 32'sd100;
    coef_val = 18'sd1;
    run(32'd0, 1, "sat");
    rd(REG_ACC, sat_acc_exp, "sat_acc");
    rd(REG_STATUS, sat_status_exp, "sat_status");

    // Signed product -3*5 into 0; START clears the sticky flag.
    mem[0]   = -32'sd3;
    coef_val = 18'sd5;
    wr(REG_ACC, 32'd0);
    run(32'd0, 1, "neg");
    rd(REG_ACC, 32'hFFFF_FFF1, "neg_acc");
    rd(REG_STATUS, 32'd0, "neg_status");

    // Byte address 0x200 is word 128; stride 256 -> words 128,384: -15+(2+4)*5 = 15.
    wr(REG_VEC_ADDR, 32'h0000_0200);
    wr(REG_ADDR_STRIDE, 32'd256);
    wr(REG_TAPS, 32'd2);
    run(32'd0, 2, "vec");
    chk("vec_addr0", 32'(addr_log[0]), 32'd128);
    chk("vec_addr1", 32'(addr_log[1]), 32'd384);
    rd(REG_ACC, 32'd15, "vec_acc");

    // Reset in the middle of a run.
    mem[0]   = 32'sd1;
    coef_val = 18'sd2;
    wr(REG_VEC_ADDR, 32'd0);
    wr(REG_ADDR_STRIDE, 32'd128);
    wr(REG_TAPS, 32'd8);
    dn_before = done_count;
    cpu(1'b1, REG_START, 32'd0, 32'd0, "abort_start_rsp", s_unused);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_rd_en", 32'(mem_rd_en), 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(done_count - dn_before), 32'd0);
    rd(REG_STATUS, 32'd0, "abort_idle");
    rd(REG_ACC, 32'd0, "abort_acc0");
    wr(REG_CH_SEL, 32'd1);
    rd(REG_ACC, 32'd0, "abort_acc1");
    wr(REG_CH_SEL, 32'd0);
    run(32'd0, 8, "rerun");
    rd(REG_ACC, 32'd72, "rerun_acc");

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
